// File: rtl/pc_gen.sv
// Program counter and fetch-request generator for the NPC front end.
// Resolves trap/redirect/stall and buffers events while a request is held.
module pc_gen #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] RESET_VEC   = 32'h8000_0000,
  parameter int unsigned IALIGN_BITS = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_tgt_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             if_valid_o,
  output logic [XLEN-1:0]  if_addr_o,
  input  logic             if_ready_i,
  output logic             misalign_o,
  output logic [XLEN-1:0]  misalign_addr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HALTED
  } state_t;

  localparam logic [XLEN-1:0] RST_PC =
    XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] LOW_MASK =
    XLEN'((64'd1 << IALIGN_BITS) - 64'd1);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            pend_v;
  logic            pend_trap;
  logic [XLEN-1:0] pend_addr;

  logic            fire;
  logic            held;
  logic            redir_bad;
  logic            redir_ok;
  logic            ev_v;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] ev_addr;
  logic            pend_wr;
  logic            halt_go;
  logic            valid_nxt;
  logic [XLEN-1:0] pc_nxt;

  assign fire = if_valid_o & if_ready_i;
  assign held = if_valid_o & ~if_ready_i;

  assign redir_bad = redirect_i
                   & (|(redirect_tgt_i & LOW_MASK));
  assign redir_ok  = redirect_i & ~redir_bad;
  assign ev_v      = trap_i | redir_ok;
  assign trap_tgt  = trap_vec_i & ~LOW_MASK;
  assign ev_addr   = trap_i ? trap_tgt
                            : redirect_tgt_i;

  // A redirect must not displace a trap already waiting in the buffer.
  assign pend_wr = held & ev_v
                 & (trap_i | ~(pend_v & pend_trap));

  assign halt_go = (state == ISSUE) & halt_i & ~held;

  always_comb begin
    valid_nxt = 1'b0;
    if (held)
      valid_nxt = 1'b1;
    else if (state == ISSUE && !halt_i)
      valid_nxt = ~stall_i;
  end

  always_comb begin
    pc_nxt = pc;
    if (ev_v)
      pc_nxt = ev_addr;
    else if (pend_v)
      pc_nxt = pend_addr;
    else if (fire)
      pc_nxt = pc + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    state <= ISSUE;
        ISSUE:   if (halt_go) state <= HALTED;
        HALTED:  if (resume_i | trap_i) state <= ISSUE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_o <= 1'b0;
    end else begin
      if_valid_o <= valid_nxt;
    end
  end

  // The address must stay stable while the request is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RST_PC;
      pend_v    <= 1'b0;
      pend_trap <= 1'b0;
      pend_addr <= '0;
    end else if (held) begin
      if (pend_wr) begin
        pend_v    <= 1'b1;
        pend_trap <= trap_i;
        pend_addr <= ev_addr;
      end
    end else if (state != IDLE) begin
      pc <= pc_nxt;
      if (ev_v || pend_v) begin
        pend_v    <= 1'b0;
        pend_trap <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o <= redir_bad & ~trap_i;
      if (redir_bad && !trap_i)
        misalign_addr_o <= redirect_tgt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= '0;
    end else if (fire) begin
      fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
    end
  end

  assign if_addr_o = pc;
  assign halted_o  = (state == HALTED);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetch addresses are queued by the
// stimulus and popped by a monitor on every accepted fetch.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_tgt_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic        halt_i;
  logic        resume_i;
  logic        if_valid_o;
  logic [31:0] if_addr_o;
  logic        if_ready_i;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
  logic        halted_o;
  logic [3:0]  fetch_cnt_o;

  int tests;
  int fails;
  int nfire;
  logic [31:0] exp_q[$];

  pc_gen #(
    .XLEN(32),
    .RESET_VEC(32'h8000_0000),
    .IALIGN_BITS(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .redirect_i(redirect_i),
    .redirect_tgt_i(redirect_tgt_i),
    .trap_i(trap_i),
    .trap_vec_i(trap_vec_i),
    .halt_i(halt_i),
    .resume_i(resume_i),
    .if_valid_o(if_valid_o),
    .if_addr_o(if_addr_o),
    .if_ready_i(if_ready_i),
    .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o),
    .halted_o(halted_o),
    .fetch_cnt_o(fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a fetch is accepted at the next rising edge.
  always @(negedge clk) begin
    if (!rst && if_valid_o && if_ready_i) begin
      nfire++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fetch_addr: got %h, none expected",
                 if_addr_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (if_addr_o !== e) begin
          fails++;
          $display("FAIL fetch_addr: got %h want %h",
                   if_addr_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_fires(input int n);
    int target;
    int budget;
    target = nfire + n;
    budget = 0;
    if_ready_i = 1'b1;
    while (nfire < target && budget < 50) begin
      tick();
      budget++;
    end
    if_ready_i = 1'b0;
    if (nfire < target) begin
      tests++;
      fails++;
      $display("FAIL fire_timeout: got %0d want %0d",
               nfire, target);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_i     = 1'b1;
    redirect_tgt_i = tgt;
    tick();
    redirect_i     = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    nfire = 0;
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_tgt_i = '0;
    trap_i = 1'b0;
    trap_vec_i = '0;
    halt_i = 1'b0;
    resume_i = 1'b0;
    if_ready_i = 1'b0;

    // reset / boot
    tick();
    tick();
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_addr", if_addr_o, 32'h8000_0000);
    chk("rst_cnt", 32'(fetch_cnt_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_maddr", misalign_addr_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(if_valid_o), 32'd0);
    tick();
    chk("boot_valid", 32'(if_valid_o), 32'd1);
    chk("boot_addr", if_addr_o, 32'h8000_0000);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    exp_q.push_back(32'h8000_000C);
    run_fires(4);
    chk("boot_cnt", 32'(fetch_cnt_o), 32'd4);
    chk("boot_pc", if_addr_o, 32'h8000_0010);

    // redirect while held
    redirect(32'h8000_0100);
    chk("held_addr0", if_addr_o, 32'h8000_0010);
    tick();
    chk("held_addr1", if_addr_o, 32'h8000_0010);
    chk("held_valid", 32'(if_valid_o), 32'd1);
    exp_q.push_back(32'h8000_0010);
    exp_q.push_back(32'h8000_0100);
    run_fires(2);

    // priority: trap beats redirect, later redirect cannot displace it
    redirect(32'h8000_0200);
    trap_i = 1'b1;
    trap_vec_i = 32'h8000_0004;
    redirect(32'h8000_0300);
    trap_i = 1'b0;
    redirect(32'h8000_0400);
    chk("prio_held", if_addr_o, 32'h8000_0104);
    exp_q.push_back(32'h8000_0104);
    exp_q.push_back(32'h8000_0004);
    run_fires(2);
    chk("prio_pc", if_addr_o, 32'h8000_0008);

    // misaligned redirect dropped
    redirect(32'h8000_0102);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_addr", misalign_addr_o, 32'h8000_0102);
    tick();
    chk("mis_clear", 32'(misalign_o), 32'd0);
    exp_q.push_back(32'h8000_0008);
    exp_q.push_back(32'h8000_000C);
    run_fires(2);
    chk("mis_seq", if_addr_o, 32'h8000_0010);

    // misaligned redirect with trap: trap wins, vector low bits cleared
    trap_i = 1'b1;
    trap_vec_i = 32'h8000_0013;
    redirect(32'h8000_0106);
    trap_i = 1'b0;
    chk("mis_trap", 32'(misalign_o), 32'd0);
    chk("mis_keep", misalign_addr_o, 32'h8000_0102);
    exp_q.push_back(32'h8000_0010);
    exp_q.push_back(32'h8000_0010);
    run_fires(2);
    chk("trap_pc", if_addr_o, 32'h8000_0014);

    // halt while held, then resume
    halt_i = 1'b1;
    tick();
    tick();
    chk("halt_wait", 32'(halted_o), 32'd0);
    chk("halt_wait_v", 32'(if_valid_o), 32'd1);
    exp_q.push_back(32'h8000_0014);
    run_fires(1);
    chk("halted", 32'(halted_o), 32'd1);
    chk("halted_v", 32'(if_valid_o), 32'd0);
    halt_i = 1'b0;
    tick();
    tick();
    chk("halted_stay", 32'(halted_o), 32'd1);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    chk("resumed", 32'(halted_o), 32'd0);
    tick();
    chk("resume_v", 32'(if_valid_o), 32'd1);
    chk("resume_pc", if_addr_o, 32'h8000_0018);
    exp_q.push_back(32'h8000_0018);
    run_fires(1);
    chk("cnt14", 32'(fetch_cnt_o), 32'd14);

    // stall
    stall_i = 1'b1;
    tick();
    chk("stall_held", 32'(if_valid_o), 32'd1);
    exp_q.push_back(32'h8000_001C);
    run_fires(1);
    chk("stall_v", 32'(if_valid_o), 32'd0);
    chk("stall_cnt", 32'(fetch_cnt_o), 32'd15);
    if_ready_i = 1'b1;
    tick();
    tick();
    tick();
    if_ready_i = 1'b0;
    chk("stall_frz", 32'(fetch_cnt_o), 32'd15);
    stall_i = 1'b0;
    tick();
    chk("unstall_v", 32'(if_valid_o), 32'd1);
    chk("unstall_pc", if_addr_o, 32'h8000_0020);

    // counter and PC wrap
    redirect(32'hFFFF_FFFC);
    exp_q.push_back(32'h8000_0020);
    run_fires(1);
    chk("cnt_wrap", 32'(fetch_cnt_o), 32'd0);
    chk("pc_top", if_addr_o, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    run_fires(1);
    chk("pc_wrap", if_addr_o, 32'h0000_0000);
    chk("cnt_one", 32'(fetch_cnt_o), 32'd1);

    // reset mid-operation discards pending redirect
    redirect(32'h8000_0500);
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(if_valid_o), 32'd0);
    chk("mrst_addr", if_addr_o, 32'h8000_0000);
    chk("mrst_cnt", 32'(fetch_cnt_o), 32'd0);
    chk("mrst_maddr", misalign_addr_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_idle", 32'(if_valid_o), 32'd0);
    tick();
    chk("mrst_v", 32'(if_valid_o), 32'd1);
    exp_q.push_back(32'h8000_0000);
    run_fires(1);
    chk("mrst_pc", if_addr_o, 32'h8000_0004);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
